datapath: RTL and testbench



---
 rtl/datapath_if.sv | 74 +++++++
 rtl/datapath.sv | 129 ++++++++++++
 tb/tb_datapath.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/datapath_if.sv
// -----------------------------------------------------------------------------
// k_and_s_pkg  : shared types for the K&S processor (instruction decode,
//                ALU operation select, status flags).
// datapath_if  : control/RAM bundle between control_unit, RAM and datapath.
//   master : driven by control unit / RAM side (strobes, operation, data_in)
//   slave  : the datapath (decoded_instruction, flags, ram_addr, data_out)
// -----------------------------------------------------------------------------
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_BRANCH,
    I_BZERO,
    I_BNEG,
    I_HALT
  } decoded_instruction_type;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic unsigned_ov;
    logic signed_ov;
  } flags_t;

endpackage

interface datapath_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                            branch;
  logic                            pc_enable;
  logic                            ir_enable;
  logic                            write_reg_enable;
  logic                            addr_sel;
  logic                            c_sel;
  logic [1:0]                      operation;
  logic                            flags_reg_enable;
  k_and_s_pkg::decoded_instruction_type decoded_instruction;
  logic                            zero_op;
  logic                            neg_op;
  logic                            unsigned_overflow;
  logic                            signed_overflow;
  logic [ADDR_WIDTH-1:0]           ram_addr;
  logic [15:0]                     data_in;
  logic [15:0]                     data_out;

  modport master (
    output branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel,
           operation, flags_reg_enable, data_in,
    input  decoded_instruction, zero_op, neg_op, unsigned_overflow,
           signed_overflow, ram_addr, data_out
  );

  modport slave (
    input  branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel,
           operation, flags_reg_enable, data_in,
    output decoded_instruction, zero_op, neg_op, unsigned_overflow,
           signed_overflow, ram_addr, data_out
  );
endinterface

// File: rtl/datapath.sv
// -----------------------------------------------------------------------------
// datapath : execution datapath of the K&S processor.
//   Holds PC, IR, a 4x16 register file, the ALU and the flags register.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : datapath_if.slave -- control strobes and RAM data in; decoded
//          instruction, registered flags, RAM address and write data out.
// -----------------------------------------------------------------------------
module datapath
  import k_and_s_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic      clk,
  input  logic      rst,
  datapath_if.slave bus
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]           ir_q, ir_d;
  logic [15:0]           regs_q [4];
  logic [15:0]           regs_d [4];
  flags_t                flags_q, flags_d;

  decoded_instruction_type dec;
  logic [1:0]              r_c, r_a, r_b;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [15:0]             alu_a, alu_b, alu_res, wr_data;
  logic [16:0]             alu_wide;
  flags_t                  alu_flags;

  // Opcode/padding bits not otherwise used are folded into a sink.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir_q[11:4];

  assign r_c  = ir_q[9:8];
  assign r_a  = ir_q[3:2];
  assign r_b  = ir_q[1:0];
  assign addr = ir_q[ADDR_WIDTH-1:0];

  // Decode depends on the IR only, never on strobes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    dec = I_NOP;
    case (ir_q[15:12])
      4'h1:    dec = I_LOAD;
      4'h2:    dec = I_STORE;
      4'h3:    dec = I_MOVE;
      4'h4:    dec = I_ADD;
      4'h5:    dec = I_SUB;
      4'h6:    dec = I_AND;
      4'h7:    dec = I_OR;
      4'h8:    dec = I_BRANCH;
      4'h9:    dec = I_BZERO;
      4'hA:    dec = I_BNEG;
      4'hF:    dec = I_HALT;
      default: dec = I_NOP;
    endcase
  end

  // ALU. MOVE is issued as ADD with B forced to zero, yielding R[r_a].
  always_comb begin
    alu_a     = regs_q[r_a];
    alu_b     = (dec == I_MOVE) ? 16'h0000 : regs_q[r_b];
    alu_wide  = '0;
    alu_flags = '0;
    case (alu_op_e'(bus.operation))
      ALU_ADD: begin
        alu_wide              = {1'b0, alu_a} + {1'b0, alu_b};
        alu_flags.unsigned_ov = alu_wide[16];
        alu_flags.signed_ov   = (alu_a[15] == alu_b[15]) && (alu_wide[15] != alu_a[15]);
      end
      ALU_SUB: begin
        // Bit 16 of the widened difference is the borrow, i.e. A < B unsigned.
        alu_wide              = {1'b0, alu_a} - {1'b0, alu_b};
        alu_flags.unsigned_ov = alu_wide[16];
        alu_flags.signed_ov   = (alu_a[15] != alu_b[15]) && (alu_wide[15] != alu_a[15]);
      end
      ALU_AND: alu_wide = {1'b0, alu_a & alu_b};
      ALU_OR:  alu_wide = {1'b0, alu_a | alu_b};
      default: alu_wide = '0;
    endcase
    alu_res        = alu_wide[15:0];
    alu_flags.zero = (alu_res == 16'h0000);
    alu_flags.neg  = alu_res[15];
  end

  // Next-state for PC, IR, register file and flags.
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    regs_d  = regs_q;
    flags_d = flags_q;
    wr_data = bus.c_sel ? bus.data_in : alu_res;

    if (bus.pc_enable) pc_d = bus.branch ? addr : pc_q + 1'b1;
    if (bus.ir_enable) ir_d = bus.data_in;
    // Sources above read regs_q, so r_c == r_a sees the pre-write value.
    if (bus.write_reg_enable) regs_d[r_c] = wr_data;
    if (bus.flags_reg_enable) flags_d = alu_flags;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      ir_q    <= '0;
      // NOTE: the register file is only four words, so it is cleared on
      // reset like ordinary flops rather than left as uninitialised memory.
      regs_q  <= '{default: '0};
      flags_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      regs_q  <= regs_d;
      flags_q <= flags_d;
    end
  end

  assign bus.decoded_instruction = dec;
  assign bus.ram_addr            = bus.addr_sel ? pc_q : addr;
  assign bus.data_out            = regs_q[r_c];
  assign bus.zero_op             = flags_q.zero;
  assign bus.neg_op              = flags_q.neg;
  assign bus.unsigned_overflow   = flags_q.unsigned_ov;
  assign bus.signed_overflow     = flags_q.signed_ov;

endmodule

// File: tb/tb_datapath.sv
// -----------------------------------------------------------------------------
// tb_datapath : directed self-checking bench for datapath (ADDR_WIDTH = 5).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// Flags are compared as {zero, neg, unsigned_overflow, signed_overflow}.
// -----------------------------------------------------------------------------
module tb_datapath;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  datapath_if #(.ADDR_WIDTH(5)) bus ();

  datapath #(.ADDR_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {bus.zero_op, bus.neg_op, bus.unsigned_overflow, bus.signed_overflow};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.branch           = 1'b0;
    bus.pc_enable        = 1'b0;
    bus.ir_enable        = 1'b0;
    bus.write_reg_enable = 1'b0;
    bus.c_sel            = 1'b0;
    bus.flags_reg_enable = 1'b0;
  endtask

  task automatic load_ir(input logic [15:0] v);
    bus.data_in   = v;
    bus.ir_enable = 1'b1;
    tick();
    bus.ir_enable = 1'b0;
  endtask

  // LOAD into R[n] from data_in.
  task automatic set_reg(input logic [1:0] n, input logic [15:0] v);
    load_ir({4'h1, 2'b00, n, 8'h00});
    bus.data_in          = v;
    bus.c_sel            = 1'b1;
    bus.write_reg_enable = 1'b1;
    tick();
    idle();
  endtask

  // One ALU instruction with optional write-back and flag update.
  task automatic alu_op(input logic [15:0] instr, input logic [1:0] op,
                        input logic wr, input logic fl);
    load_ir(instr);
    bus.operation        = op;
    bus.c_sel            = 1'b0;
    bus.write_reg_enable = wr;
    bus.flags_reg_enable = fl;
    tick();
    idle();
  endtask

  initial begin
    rst           = 1'b1;
    idle();
    bus.addr_sel  = 1'b1;
    bus.operation = 2'b00;
    bus.data_in   = 16'h0000;
    #2;
    check("por_ram_addr", 32'(bus.ram_addr), 32'd0);
    check("por_decode", 32'(bus.decoded_instruction), 32'(I_NOP));
    check("por_flags", 32'(flags()), 32'h0);
    #10 rst = 1'b0;

    // ---- Reset mid-instruction: pc=7, R1=0x1234, flags non-zero ----
    load_ir(16'h8007);
    bus.pc_enable = 1'b1; bus.branch = 1'b1;
    tick();
    idle();
    set_reg(2'd1, 16'h1234);
    alu_op(16'h5001, 2'b01, 1'b0, 1'b1);           // 0 - 0x1234 = 0xEDCC
    check("pre_rst_pc", 32'(bus.ram_addr), 32'd7);
    check("pre_rst_flags", 32'(flags()), 32'b0110);
    check("pre_rst_decode", 32'(bus.decoded_instruction), 32'(I_SUB));
    #2 rst = 1'b1;
    #1;
    check("rst_pc", 32'(bus.ram_addr), 32'd0);
    check("rst_decode", 32'(bus.decoded_instruction), 32'(I_NOP));
    check("rst_flags", 32'(flags()), 32'h0);
    tick();
    check("rst_hold_pc", 32'(bus.ram_addr), 32'd0);
    rst = 1'b0;
    load_ir(16'h2100);
    check("rst_r1", 32'(bus.data_out), 32'h0000);

    // ---- Fetch with PC wrap ----
    load_ir(16'h801F);
    bus.pc_enable = 1'b1; bus.branch = 1'b1;
    tick();
    idle();
    bus.addr_sel  = 1'b1;
    bus.data_in   = 16'h4000;
    bus.ir_enable = 1'b1;
    bus.pc_enable = 1'b1;
    bus.branch    = 1'b0;
    #1;
    check("fetch_addr_pre", 32'(bus.ram_addr), 32'd31);
    tick();
    idle();
    check("fetch_decode", 32'(bus.decoded_instruction), 32'(I_ADD));
    check("fetch_pc_wrap", 32'(bus.ram_addr), 32'd0);

    // ---- ADD signed overflow ----
    set_reg(2'd0, 16'h7FFF);
    set_reg(2'd1, 16'h0001);
    alu_op(16'h4201, 2'b00, 1'b1, 1'b1);
    check("add_r2", 32'(bus.data_out), 32'h8000);
    check("add_flags", 32'(flags()), 32'b0101);

    // ---- SUB borrow, then zero ----
    set_reg(2'd0, 16'h0003);
    set_reg(2'd1, 16'h0005);
    alu_op(16'h5201, 2'b01, 1'b1, 1'b1);
    check("sub_r2", 32'(bus.data_out), 32'hFFFE);
    check("sub_flags", 32'(flags()), 32'b0110);
    set_reg(2'd0, 16'h0005);
    check("flags_hold", 32'(flags()), 32'b0110);
    alu_op(16'h5201, 2'b01, 1'b1, 1'b1);
    check("subz_r2", 32'(bus.data_out), 32'h0000);
    check("subz_flags", 32'(flags()), 32'b1000);

    // ---- Destination equals source: R1 = R1 + R1 (old value 5) ----
    alu_op(16'h4105, 2'b00, 1'b1, 1'b0);
    check("self_add_r1", 32'(bus.data_out), 32'h000A);
    check("self_add_flags_held", 32'(flags()), 32'b1000);

    // ---- LOAD / STORE ----
    load_ir(16'h1314);
    bus.addr_sel = 1'b0;
    #1;
    check("load_addr", 32'(bus.ram_addr), 32'h14);
    bus.data_in = 16'hBEEF; bus.c_sel = 1'b1; bus.write_reg_enable = 1'b1;
    tick();
    idle();
    load_ir(16'h2314);
    check("store_data", 32'(bus.data_out), 32'hBEEF);
    check("store_addr", 32'(bus.ram_addr), 32'h14);
    check("store_decode", 32'(bus.decoded_instruction), 32'(I_STORE));

    // ---- Branch, then PC+1 held over two edges ----
    load_ir(16'h9009);
    check("bzero_decode", 32'(bus.decoded_instruction), 32'(I_BZERO));
    bus.pc_enable = 1'b1; bus.branch = 1'b1;
    tick();
    bus.branch = 1'b0;
    bus.addr_sel = 1'b1;
    check("branch_pc", 32'(bus.ram_addr), 32'd9);
    tick();
    tick();
    idle();
    check("pc_inc_twice", 32'(bus.ram_addr), 32'd11);
    tick();
    check("pc_hold", 32'(bus.ram_addr), 32'd11);

    // ---- MOVE (R0 = 5 must not leak in through B) ----
    set_reg(2'd1, 16'h00AA);
    load_ir(16'h3104);
    check("move_decode", 32'(bus.decoded_instruction), 32'(I_MOVE));
    alu_op(16'h3104, 2'b00, 1'b1, 1'b0);
    check("move_r1", 32'(bus.data_out), 32'h00AA);
    alu_op(16'h3204, 2'b00, 1'b1, 1'b0);
    check("move_r2", 32'(bus.data_out), 32'h00AA);

    // ---- AND / OR: R3 = R1 op R2 ----
    set_reg(2'd2, 16'h8F0F);
    alu_op(16'h6306, 2'b10, 1'b1, 1'b1);
    check("and_r3", 32'(bus.data_out), 32'h000A);
    check("and_flags", 32'(flags()), 32'b0000);
    alu_op(16'h7306, 2'b11, 1'b1, 1'b1);
    check("or_r3", 32'(bus.data_out), 32'h8FAF);
    check("or_flags", 32'(flags()), 32'b0100);

    // ---- Remaining decodes ----
    load_ir(16'hC000);
    check("dec_C_nop", 32'(bus.decoded_instruction), 32'(I_NOP));
    load_ir(16'hF000);
    check("dec_halt", 32'(bus.decoded_instruction), 32'(I_HALT));
    load_ir(16'hA000);
    check("dec_bneg", 32'(bus.decoded_instruction), 32'(I_BNEG));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
